gpu_timing: RTL
===============

# gpu_timing

Video timing generator for the GPU. Produces the `pixel`/`line` raster counters that feed the GPU status register, plus HSYNC/VSYNC/active-video strobes for the display output. Also exposes one CPU-writable/readable control register on the shared data bus, with enable, vertical-blank interrupt enable and interrupt-pending bits. It sits between the CPU data bus and the display pins, alongside the status register at 0x70000000.

## Interface
- `ADDRESS`, default 'h70000004: byte address of the control register; matched against `data_address` as `ADDRESS >> 2`.
- `CLK_DIV`, default 4: number of `cpu_clk` cycles per pixel; must be ≥1.
- `H_ACTIVE` / `H_FP` / `H_SYNC` / `H_BP`, defaults 640/16/96/48: horizontal timing in pixels.
- `V_ACTIVE` / `V_FP` / `V_SYNC` / `V_BP`, defaults 480/10/2/33: vertical timing in lines.
- `cpu_clk`  in  1  the only clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `data_address`  in  30  CPU word address.
- `data_bus`  inout  32  CPU data bus; driven only during a matching read, otherwise high-Z.
- `data_cs`  in  1  bus chip select.
- `data_rw`  in  1  bus direction: 1 = write, 0 = read.
- `pixel`  out  16  current horizontal position, 0..H_TOTAL-1.
- `line`  out  16  current vertical position, 0..V_TOTAL-1.
- `pixel_tick`  out  1  one-cycle pulse on the cycle the counters advance.
- `hsync`  out  1  horizontal sync, active-low.
- `vsync`  out  1  vertical sync, active-low.
- `active`  out  1  high while inside the visible area.
- `vblank_irq`  out  1  level interrupt, equal to `pending & irq_en`.

## Operation
- Totals: H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters. Both must be ≤ 65535.
- Control register bits: bit0 `enable` (reset 1), bit1 `irq_en` (reset 0), bit2 `pending` (reset 0). Bits 31:3 read as 0.
- **Bus write** (`data_cs=1`, `data_rw=1`, address match):
  - `enable` and `irq_en` load from bus bits 0 and 1.
  - Writing 1 to bit2 clears `pending`; writing 0 to bit2 has no effect.
- **Bus read** (`data_cs=1`, `data_rw=0`, address match): combinationally drives `{29'b0, pending, irq_en, enable}`. Any other bus state leaves the bus at Z.
- **Pixel divider:** `div` counts 0..CLK_DIV-1 while `enable`=1. `pixel_tick`=1 exactly when `enable` and `div`==CLK_DIV-1.
- **Counter advance on `pixel_tick`:**
  - `pixel` increments.
  - At H_TOTAL-1, `pixel` wraps to 0 and `line` increments.
  - At V_TOTAL-1 with `pixel` wrap, `line` also wraps to 0.
- **`enable`=0:** `div`, `pixel` and `line` are forced to 0 every cycle; `hsync`=`vsync`=1; `active`=0. Re-enabling restarts the frame at (0,0).
- **Decode** (combinational from the registered counters, gated by `enable`):
  - `active` = `pixel` < H_ACTIVE && `line` < V_ACTIVE.
  - `hsync`=0 iff H_ACTIVE+H_FP ≤ `pixel` < H_ACTIVE+H_FP+H_SYNC.
  - `vsync`=0 iff V_ACTIVE+V_FP ≤ `line` < V_ACTIVE+V_FP+V_SYNC.
- **`pending` set:** on the `pixel_tick` that moves (pixel, line) from (H_TOTAL-1, V_ACTIVE-1) to (0, V_ACTIVE). Set takes priority over a same-cycle write-1 clear.
- **Reset:** `pixel`=0, `line`=0, `div`=0, `enable`=1, `irq_en`=0, `pending`=0. After reset, outputs are `hsync`=1, `vsync`=1, `active`=1, `pixel_tick`=0, `vblank_irq`=0.

## Timing
- Counters change one cycle after the `pixel_tick` cycle, i.e. on the clock edge that samples the tick.
- `pixel`, `line`, `hsync`, `vsync` and `active` are mutually aligned, with no skew.
- Register write takes effect the cycle after the write. Read data is valid in the same cycle as the request.
- `rst` asserted mid-frame returns the block to its reset values on the next edge, regardless of any bus access in that cycle.
- With CLK_DIV=1, `pixel_tick` is held high continuously while enabled.

## Structure
- Shared package `gpu_pkg` holds:
  - bus address constants (STATUS 'h70000000, TIMING 'h70000004);
  - control bit positions (CTL_ENABLE=0, CTL_IRQ_EN=1, CTL_PENDING=2).
- A single module, with no sub-modules. Horizontal and vertical counters live inline.

## Test plan
All scenarios use CLK_DIV=2, H 8/1/2/1 (H_TOTAL 12) and V 4/1/1/1 (V_TOTAL 7).
- **Reset, then free-run:** `pixel_tick` every 2nd cycle; `pixel` sequence 0..11,0; `line` increments on each `pixel` wrap; a full frame takes 168 cycles.
- **Sync decode:** `hsync`=0 exactly for `pixel`=9,10; `vsync`=0 exactly for `line`=5; `active`=1 only for `pixel`<8 and `line`<4.
- **Interrupt:** write 0x3, run to (0,4) → `pending`=1 and `vblank_irq`=1. Write 0x7 → next cycle `pending`=0 and `enable`/`irq_en` stay 1. A write of 0x7 landing on the set cycle leaves `pending`=1.
- **Read-back:** after writing 0x2 → read returns 0x00000002 and counters sit at 0 with `hsync`=1. A read at `data_address` 'h1C000000 drives Z on this block.
- **Disable mid-frame:** at (5,2) write 0x0 → next cycle counters are 0 and `active`=0. Write 0x1 → first `pixel_tick` 2 cycles later.
- **Reset mid-frame:** pulse `rst` at (10,6) → next cycle counters are 0, `enable`=1, `pending`=0.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU bus map and control-register bit positions.
package gpu_pkg;
   localparam logic [31:0] ADDR_STATUS = 32'h7000_0000;
   localparam logic [31:0] ADDR_TIMING = 32'h7000_0004;

   localparam int CTL_ENABLE  = 0;
   localparam int CTL_IRQ_EN  = 1;
   localparam int CTL_PENDING = 2;
endpackage

// File: rtl/gpu_timing.sv
// Video raster timing generator with a CPU control register (enable, vblank irq).
module gpu_timing
   import gpu_pkg::*;
#(
   parameter logic [31:0] ADDRESS  = ADDR_TIMING,
   parameter int          CLK_DIV  = 4,
   parameter int          H_ACTIVE = 640,
   parameter int          H_FP     = 16,
   parameter int          H_SYNC   = 96,
   parameter int          H_BP     = 48,
   parameter int          V_ACTIVE = 480,
   parameter int          V_FP     = 10,
   parameter int          V_SYNC   = 2,
   parameter int          V_BP     = 33
) (
   input  logic        cpu_clk,
   input  logic        rst,
   input  logic [29:0] data_address,
   inout  wire  [31:0] data_bus,
   input  logic        data_cs,
   input  logic        data_rw,
   output logic [15:0] pixel,
   output logic [15:0] line,
   output logic        pixel_tick,
   output logic        hsync,
   output logic        vsync,
   output logic        active,
   output logic        vblank_irq
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [15:0]   H_LAST   = 16'(H_TOTAL - 1);
   localparam logic [15:0]   V_LAST   = 16'(V_TOTAL - 1);
   localparam logic [15:0]   VA_LAST  = 16'(V_ACTIVE - 1);
   localparam logic [15:0]   HS_START = 16'(H_ACTIVE + H_FP);
   localparam logic [15:0]   HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [15:0]   VS_START = 16'(V_ACTIVE + V_FP);
   localparam logic [15:0]   VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_q, div_d;
   logic [15:0]   pixel_q, pixel_d, line_q, line_d;
   logic          enable_q, enable_d, irq_en_q, irq_en_d, pending_q, pending_d;
   logic          sel, wr, rd, tick;
   logic [31:0]   ctl_rd;

   assign sel  = data_cs && (data_address == ADDRESS[31:2]);
   assign wr   = sel && data_rw;
   assign rd   = sel && !data_rw;
   assign tick = enable_q && (div_q == DIV_LAST);

   always_comb begin
      ctl_rd              = '0;
      ctl_rd[CTL_ENABLE]  = enable_q;
      ctl_rd[CTL_IRQ_EN]  = irq_en_q;
      ctl_rd[CTL_PENDING] = pending_q;
   end

   assign data_bus = rd ? ctl_rd : 'z;

   always_comb begin
      enable_d  = enable_q;
      irq_en_d  = irq_en_q;
      pending_d = pending_q;
      div_d     = div_q + 1'b1;
      pixel_d   = pixel_q;
      line_d    = line_q;

      if (wr) begin
         enable_d = data_bus[CTL_ENABLE];
         irq_en_d = data_bus[CTL_IRQ_EN];
         if (data_bus[CTL_PENDING]) pending_d = 1'b0;
      end
      // Entering the first blanking line wins over a same-cycle clear.
      if (tick && pixel_q == H_LAST && line_q == VA_LAST) pending_d = 1'b1;

      if (tick) begin
         div_d = '0;
         if (pixel_q == H_LAST) begin
            pixel_d = '0;
            line_d  = (line_q == V_LAST) ? 16'd0 : line_q + 16'd1;
         end else begin
            pixel_d = pixel_q + 16'd1;
         end
      end

      // Disabling zeroes the raster on the very next edge; re-enable restarts at (0,0).
      if (!enable_q || !enable_d) begin
         div_d   = '0;
         pixel_d = '0;
         line_d  = '0;
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (rst) begin
         div_q     <= '0;
         pixel_q   <= '0;
         line_q    <= '0;
         enable_q  <= 1'b1;
         irq_en_q  <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         div_q     <= div_d;
         pixel_q   <= pixel_d;
         line_q    <= line_d;
         enable_q  <= enable_d;
         irq_en_q  <= irq_en_d;
         pending_q <= pending_d;
      end
   end

   assign pixel      = pixel_q;
   assign line       = line_q;
   assign pixel_tick = tick;
   assign active     = enable_q && (pixel_q < 16'(H_ACTIVE)) && (line_q < 16'(V_ACTIVE));
   assign hsync      = !(enable_q && pixel_q >= HS_START && pixel_q < HS_END);
   assign vsync      = !(enable_q && line_q >= VS_START && line_q < VS_END);
   assign vblank_irq = pending_q & irq_en_q;
endmodule
